ula_addsub_serial: RTL and testbench



---
 rtl/ula_pkg.sv | 22 ++
 rtl/ula_addsub_serial_if.sv | 35 +++
 rtl/ula_addsub_digit.sv | 23 ++
 rtl/ula_addsub_serial.sv | 137 +++++++++++++
 tb/tb_ula_addsub_serial.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/ula_pkg.sv
// Shared types and helpers for the digit-serial ULA add/sub stage.
package ula_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic MODO_ADD = 1'b0;
  localparam logic MODO_SUB = 1'b1;

  function automatic int num_digits(input int width, input int digit);
    return width / digit;
  endfunction

  // Counter also has to hold N itself (the finalize step), hence N+1 codes.
  function automatic int cnt_width(input int width, input int digit);
    return $clog2(width / digit + 1);
  endfunction

endpackage

// File: rtl/ula_addsub_serial_if.sv
// Operand/result handshake bundle for ula_addsub_serial.
// ULA_SATURATE_EN adds the sat request bit.
interface ula_addsub_serial_if #(
  parameter int WIDTH   = 8,
  parameter int WIDTH_B = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH_B-1:0] b;
  logic               modo_sub;
  logic               cin_inicial;
`ifdef ULA_SATURATE_EN
  logic               sat;
`endif
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   s;
  logic               cout;
  logic               ov;
  logic               zero;
  logic               neg;

`ifdef ULA_SATURATE_EN
  modport master (output in_valid, a, b, modo_sub, cin_inicial, sat, out_ready,
                  input  in_ready, out_valid, s, cout, ov, zero, neg);
  modport slave  (input  in_valid, a, b, modo_sub, cin_inicial, sat, out_ready,
                  output in_ready, out_valid, s, cout, ov, zero, neg);
`else
  modport master (output in_valid, a, b, modo_sub, cin_inicial, out_ready,
                  input  in_ready, out_valid, s, cout, ov, zero, neg);
  modport slave  (input  in_valid, a, b, modo_sub, cin_inicial, out_ready,
                  output in_ready, out_valid, s, cout, ov, zero, neg);
`endif
endinterface

// File: rtl/ula_addsub_digit.sv
// Combinational DIGIT-bit ripple-carry slice; b arrives already inverted for subtract.
module ula_addsub_digit #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] i_a,
  input  logic [DIGIT-1:0] i_b_inv,
  input  logic             i_cin,
  output logic [DIGIT-1:0] o_sum,
  output logic             o_cout,
  output logic             o_c_top
);
  logic [DIGIT:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    assign o_sum[i]  = i_a[i] ^ i_b_inv[i] ^ w_c[i];
    assign w_c[i+1]  = (i_a[i] & i_b_inv[i]) | (w_c[i] & (i_a[i] ^ i_b_inv[i]));
  end

  assign o_cout  = w_c[DIGIT];
  assign o_c_top = w_c[DIGIT-1];
endmodule

// File: rtl/ula_addsub_serial.sv
// Digit-serial adder/subtractor: DIGIT bits per clock, LSB digit first.
// ULA_SATURATE_EN enables clamping of overflowed results when sat is requested.
module ula_addsub_serial
  import ula_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int WIDTH_B  = 4,
  parameter int DIGIT    = 2,
  parameter int B_SIGNED = 0
) (
  input logic               clk,
  input logic               rst_n,
  ula_addsub_serial_if.slave bus
);
  localparam int N  = num_digits(WIDTH, DIGIT);
  localparam int CW = cnt_width(WIDTH, DIGIT);
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [CW-1:0] FIN  = CW'(N);

  state_e           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a, r_b, r_acc;
  logic             r_c, r_cout_raw, r_ov_raw;
  logic             r_in_ready, r_out_valid;
  logic [WIDTH-1:0] r_s;
  logic             r_cout, r_ov, r_zero, r_neg;

  logic [WIDTH-1:0] w_b_ext, w_acc_nxt, w_s_fin;
  logic [DIGIT-1:0] w_sum;
  logic             w_cout, w_c_top;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bext
    if (i < WIDTH_B) begin : g_in
      assign w_b_ext[i] = bus.b[i];
    end else begin : g_ext
      assign w_b_ext[i] = (B_SIGNED != 0) ? bus.b[WIDTH_B-1] : 1'b0;
    end
  end

  ula_addsub_digit #(.DIGIT(DIGIT)) u_digit (
    .i_a     (r_a[DIGIT-1:0]),
    .i_b_inv (r_b[DIGIT-1:0]),
    .i_cin   (r_c),
    .o_sum   (w_sum),
    .o_cout  (w_cout),
    .o_c_top (w_c_top)
  );

  // Result shift register fills from the top, so after N digits the LSB digit sits at bit 0.
  if (DIGIT == WIDTH) begin : g_acc_full
    assign w_acc_nxt = w_sum;
  end else begin : g_acc_shift
    assign w_acc_nxt = {w_sum, r_acc[WIDTH-1:DIGIT]};
  end

`ifdef ULA_SATURATE_EN
  logic r_sat;
  // A wrapped result with MSB set means the true value overflowed positively.
  always_comb begin
    w_s_fin = r_acc;
    if (r_sat && r_ov_raw)
      w_s_fin = r_acc[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
  end
`else
  assign w_s_fin = r_acc;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_c         <= 1'b0;
      r_cout_raw  <= 1'b0;
      r_ov_raw    <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_s         <= '0;
      r_cout      <= 1'b0;
      r_ov        <= 1'b0;
      r_zero      <= 1'b0;
      r_neg       <= 1'b0;
`ifdef ULA_SATURATE_EN
      r_sat       <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: if (bus.in_valid) begin
          r_a        <= bus.a;
          r_b        <= w_b_ext ^ {WIDTH{bus.modo_sub}};
          r_c        <= bus.cin_inicial ^ bus.modo_sub;
          r_cnt      <= '0;
          r_in_ready <= 1'b0;
          r_state    <= BUSY;
`ifdef ULA_SATURATE_EN
          r_sat      <= bus.sat;
`endif
        end
        BUSY: if (r_cnt == FIN) begin
          r_s         <= w_s_fin;
          r_cout      <= r_cout_raw;
          r_ov        <= r_ov_raw;
          r_zero      <= (w_s_fin == '0);
          r_neg       <= w_s_fin[WIDTH-1];
          r_out_valid <= 1'b1;
          r_state     <= DONE;
        end else begin
          r_a   <= r_a >> DIGIT;
          r_b   <= r_b >> DIGIT;
          r_acc <= w_acc_nxt;
          r_c   <= w_cout;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == LAST) begin
            r_cout_raw <= w_cout;
            r_ov_raw   <= w_cout ^ w_c_top;
          end
        end
        DONE: if (bus.out_ready) begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.s         = r_s;
  assign bus.cout      = r_cout;
  assign bus.ov        = r_ov;
  assign bus.zero      = r_zero;
  assign bus.neg       = r_neg;
endmodule

// File: tb/tb_ula_addsub_serial.sv
// Scoreboard bench: two instances (B zero-extended / sign-extended) driven in lockstep.
module tb_ula_addsub_serial;
  import ula_pkg::*;

`ifdef ULA_SATURATE_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] s;
    logic       cout;
    logic       ov;
    logic       zero;
    logic       neg;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ula_addsub_serial_if #(.WIDTH(8), .WIDTH_B(4)) if0 ();
  ula_addsub_serial_if #(.WIDTH(8), .WIDTH_B(4)) if1 ();

  assign if1.in_valid    = if0.in_valid;
  assign if1.a           = if0.a;
  assign if1.b           = if0.b;
  assign if1.modo_sub    = if0.modo_sub;
  assign if1.cin_inicial = if0.cin_inicial;
  assign if1.out_ready   = if0.out_ready;
`ifdef ULA_SATURATE_EN
  assign if1.sat         = if0.sat;
`endif

  ula_addsub_serial #(.WIDTH(8), .WIDTH_B(4), .DIGIT(2), .B_SIGNED(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0));
  ula_addsub_serial #(.WIDTH(8), .WIDTH_B(4), .DIGIT(2), .B_SIGNED(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1));

  int   n_chk = 0;
  int   n_fail = 0;
  res_t q0[$];
  res_t q1[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic res_t model(input logic [7:0] a, input logic [3:0] b, input logic sub,
                                 input logic cin, input logic sat, input bit bs);
    logic [7:0] be, bi;
    logic [8:0] sum;
    res_t r;
    be = bs ? {{4{b[3]}}, b} : {4'h0, b};
    bi = sub ? ~be : be;
    sum = {1'b0, a} + {1'b0, bi} + {8'h00, cin ^ sub};
    r.s    = sum[7:0];
    r.cout = sum[8];
    r.ov   = (a[7] == bi[7]) && (r.s[7] != a[7]);
    if (SAT_EN && sat && r.ov) r.s = a[7] ? 8'h80 : 8'h7F;
    r.zero = (r.s == 8'h00);
    r.neg  = r.s[7];
    return r;
  endfunction

  task automatic cmp_res(input string id, input res_t got, input res_t exp);
    chk({id, ".s"},    got.s,    exp.s);
    chk({id, ".cout"}, got.cout, exp.cout);
    chk({id, ".ov"},   got.ov,   exp.ov);
    chk({id, ".zero"}, got.zero, exp.zero);
    chk({id, ".neg"},  got.neg,  exp.neg);
  endtask

  always @(negedge clk) begin
    if (rst_n && if0.out_valid && if0.out_ready) begin
      if (q0.size() == 0) chk("dut0_unexpected_out", 1, 0);
      else cmp_res("dut0", {if0.s, if0.cout, if0.ov, if0.zero, if0.neg}, q0.pop_front());
    end
    if (rst_n && if1.out_valid && if1.out_ready) begin
      if (q1.size() == 0) chk("dut1_unexpected_out", 1, 0);
      else cmp_res("dut1", {if1.s, if1.cout, if1.ov, if1.zero, if1.neg}, q1.pop_front());
    end
  end

  // Returns right after the accepting edge (+1).
  task automatic do_op(input logic [7:0] a, input logic [3:0] b, input logic sub,
                       input logic cin, input logic sat);
    int t = 0;
    while (!if0.in_ready && t < 100) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 100) chk("accept_timeout", 0, 1);
    if0.in_valid = 1'b1; if0.a = a; if0.b = b; if0.modo_sub = sub; if0.cin_inicial = cin;
`ifdef ULA_SATURATE_EN
    if0.sat = sat;
`endif
    q0.push_back(model(a, b, sub, cin, sat, 1'b0));
    q1.push_back(model(a, b, sub, cin, sat, 1'b1));
    @(posedge clk); #1;
    if0.in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((q0.size() != 0 || q1.size() != 0) && t < 200) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 200) chk("drain_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0] held_s;
    int lat;
    if0.in_valid = 1'b0; if0.a = '0; if0.b = '0; if0.modo_sub = MODO_ADD;
    if0.cin_inicial = 1'b0; if0.out_ready = 1'b1;
`ifdef ULA_SATURATE_EN
    if0.sat = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst.in_ready", if0.in_ready, 1);
    chk("rst.out_valid", if0.out_valid, 0);
    chk("rst.s", if0.s, 0);
    chk("rst.flags", {if0.cout, if0.ov, if0.zero, if0.neg}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // overflow add plus latency
    do_op(8'h7F, 4'h1, MODO_ADD, 1'b0, 1'b0);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (if0.out_valid) begin lat = k; break; end
    end
    chk("latency", lat, 5);
    drain();

    do_op(8'h05, 4'h7, MODO_SUB, 1'b0, 1'b0);
    do_op(8'h05, 4'h7, MODO_SUB, 1'b1, 1'b0);
    do_op(8'h09, 4'h9, MODO_SUB, 1'b0, 1'b0);
    do_op(8'h10, 4'hF, MODO_ADD, 1'b0, 1'b0);
    do_op(8'h80, 4'h1, MODO_SUB, 1'b0, 1'b0);
    do_op(8'hFF, 4'hF, MODO_ADD, 1'b1, 1'b0);
    drain();

    for (int i = 0; i < 8; i++)
      do_op(8'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    drain();

    // backpressure: hold DONE, ignored in_valid pulses
    if0.out_ready = 1'b0;
    do_op(8'h3C, 4'h5, MODO_ADD, 1'b0, 1'b0);
    lat = 0;
    while (!if0.out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    chk("bp.valid_seen", if0.out_valid, 1);
    held_s = if0.s;
    for (int k = 0; k < 10; k++) begin
      if0.in_valid = k[0]; if0.a = 8'hAA; if0.b = 4'h3;
      @(posedge clk); #1;
      chk("bp.in_ready", if0.in_ready, 0);
      chk("bp.out_valid", if0.out_valid, 1);
      chk("bp.s_stable", if0.s, held_s);
    end
    if0.in_valid = 1'b0;
    if0.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp.in_ready_after", if0.in_ready, 1);
    chk("bp.valid_dropped", if0.out_valid, 0);
    drain();

    // reset during BUSY
    do_op(8'h55, 4'h2, MODO_ADD, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    q0.delete(); q1.delete();
    @(negedge clk);
    chk("mrst.out_valid", if0.out_valid, 0);
    chk("mrst.in_ready", if0.in_ready, 1);
    chk("mrst.s", if0.s, 0);
    chk("mrst.flags", {if0.cout, if0.ov, if0.zero, if0.neg}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      chk("mrst.quiet", if0.out_valid, 0);
    end
    do_op(8'h03, 4'h4, MODO_ADD, 1'b0, 1'b0);
    drain();

    if (SAT_EN) begin
      do_op(8'h7F, 4'h1, MODO_ADD, 1'b0, 1'b1);
      do_op(8'h80, 4'h1, MODO_SUB, 1'b0, 1'b1);
      drain();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
endmodule
